// File: rtl/state_dump_unit.sv
// state_dump_unit: snapshot engine that reads architectural state out of the CPU.
// On a sampled snap_i it latches the PC, then walks the register file through a spare
// read port, streaming one PC header beat plus NUM_REGS register beats over valid/ready.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-low reset
//   snap_i         snapshot request, sampled every rising edge
//   pc_i           current PC value
//   rf_addr_o      register file read address (holds its last value outside FETCH)
//   rf_data_i      register file read data, combinational from rf_addr_o
//   dump_valid_o   stream beat valid
//   dump_ready_i   sink ready
//   dump_data_o    beat payload
//   dump_tag_o     0..31 register index, 32 PC header
//   dump_last_o    final beat of packet
//   busy_o         packet in progress (use to stall the CPU for a coherent snapshot)
//   done_o         MAX_SNAPSHOTS packets completed
//   snap_count_o   completed packets
//   overrun_o      sticky: snap_i arrived while busy
module state_dump_unit #(
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_SNAPSHOTS = 30
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  snap_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic [4:0]            rf_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [DATA_WIDTH-1:0] dump_data_o,
  output logic [5:0]            dump_tag_o,
  output logic                  dump_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [7:0]            snap_count_o,
  output logic                  overrun_o
);

  typedef enum logic [1:0] {StIdle, StHdr, StFetch, StSend} state_e;

  localparam logic [4:0] LastIdx  = 5'(NUM_REGS - 1);
  localparam logic [7:0] MaxCount = 8'(MAX_SNAPSHOTS);
  localparam logic [5:0] PcTag    = 6'd32;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [5:0]            tag_q, tag_d;
  logic                  last_q, last_d;
  logic [4:0]            idx_q, idx_d;
  logic [4:0]            addr_q, addr_d;
  logic [7:0]            count_q, count_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      data_q    <= '0;
      tag_q     <= '0;
      last_q    <= 1'b0;
      idx_q     <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    tag_d     = tag_q;
    last_d    = last_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    count_d   = count_q;
    done_d    = done_q;
    overrun_d = overrun_q;

    unique case (state_q)
      StIdle: begin
        // Requests after the snapshot limit are silently dropped.
        if (snap_i && !done_q) begin
          data_d  = pc_i;
          tag_d   = PcTag;
          last_d  = 1'b0;
          idx_d   = '0;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (dump_ready_i) state_d = StFetch;
      end
      StFetch: begin
        data_d  = rf_data_i;
        tag_d   = {1'b0, idx_q};
        last_d  = (idx_q == LastIdx);
        addr_d  = idx_q;
        state_d = StSend;
      end
      StSend: begin
        if (dump_ready_i) begin
          if (last_q) begin
            state_d = StIdle;
            if (MAX_SNAPSHOTS == 0) begin
              if (count_q != 8'hFF) count_d = count_q + 8'd1;
            end else begin
              // done_q blocks further packets, so the count stops at the limit.
              count_d = count_q + 8'd1;
              done_d  = ((count_q + 8'd1) == MaxCount);
            end
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Includes a request on the edge that completes the final handshake.
    if (state_q != StIdle && snap_i) overrun_d = 1'b1;
  end

  assign dump_valid_o = (state_q == StHdr) || (state_q == StSend);
  assign busy_o       = (state_q != StIdle);
  assign rf_addr_o    = (state_q == StFetch) ? idx_q : addr_q;
  assign dump_data_o  = data_q;
  assign dump_tag_o   = tag_q;
  assign dump_last_o  = last_q;
  assign done_o       = done_q;
  assign snap_count_o = count_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_state_dump_unit.sv
module tb_state_dump_unit;
  localparam int N  = 32;
  localparam int N2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, snap, snap2, ready;
  logic [31:0] pc;
  logic [31:0] regs [32];

  logic [4:0]  rf_addr, rf_addr2;
  logic [31:0] rf_data, rf_data2;
  assign rf_data  = regs[rf_addr];
  assign rf_data2 = regs[rf_addr2];

  logic        valid, last, busy, done, ovr;
  logic [31:0] data;
  logic [5:0]  tag;
  logic [7:0]  cnt;
  logic        valid2, last2, busy2, done2, ovr2;
  logic [31:0] data2;
  logic [5:0]  tag2;
  logic [7:0]  cnt2;

  state_dump_unit #(.NUM_REGS(N), .DATA_WIDTH(32), .MAX_SNAPSHOTS(30)) dut (
    .clk_i(clk), .rst_i(rst_n), .snap_i(snap), .pc_i(pc), .rf_addr_o(rf_addr),
    .rf_data_i(rf_data), .dump_valid_o(valid), .dump_ready_i(ready), .dump_data_o(data),
    .dump_tag_o(tag), .dump_last_o(last), .busy_o(busy), .done_o(done),
    .snap_count_o(cnt), .overrun_o(ovr)
  );

  state_dump_unit #(.NUM_REGS(N2), .DATA_WIDTH(32), .MAX_SNAPSHOTS(2)) dut_lim (
    .clk_i(clk), .rst_i(rst_n), .snap_i(snap2), .pc_i(pc), .rf_addr_o(rf_addr2),
    .rf_data_i(rf_data2), .dump_valid_o(valid2), .dump_ready_i(1'b1), .dump_data_o(data2),
    .dump_tag_o(tag2), .dump_last_o(last2), .busy_o(busy2), .done_o(done2),
    .snap_count_o(cnt2), .overrun_o(ovr2)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] got_data [$];
  logic [5:0]  got_tag  [$];
  logic        got_last [$];
  logic [31:0] exp_data [$];
  logic [5:0]  exp_tag  [$];
  logic        exp_last [$];
  int          busy_cyc, stall_viol;
  bit          pkt_done;

  // Reference packet: PC header, then every register in index order.
  function automatic void build_expected(input logic [31:0] p);
    exp_data.delete(); exp_tag.delete(); exp_last.delete();
    exp_data.push_back(p); exp_tag.push_back(6'd32); exp_last.push_back(1'b0);
    for (int i = 0; i < N; i++) begin
      exp_data.push_back(regs[i]);
      exp_tag.push_back(6'(i));
      exp_last.push_back(i == N - 1);
    end
  endfunction

  task automatic pulse_snap();
    @(negedge clk); snap = 1'b1;
    @(negedge clk); snap = 1'b0;
  endtask

  // Drives ready and records accepted beats until the last beat handshakes.
  task automatic collect(input int ovr_tag, input bit rand_rdy);
    logic [31:0] pd; logic [5:0] pt; logic pl;
    bit stall, rdy, pulsed;
    got_data.delete(); got_tag.delete(); got_last.delete();
    busy_cyc = 0; stall_viol = 0; pkt_done = 0; stall = 0; pulsed = 0;
    pd = '0; pt = '0; pl = 1'b0;
    for (int c = 0; c < 4000 && !pkt_done; c++) begin
      if (busy) busy_cyc++;
      if (stall && (!valid || data !== pd || tag !== pt || last !== pl)) stall_viol++;
      snap = (ovr_tag >= 0 && !pulsed && valid && int'(tag) == ovr_tag);
      if (snap) pulsed = 1;
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      ready = rdy;
      if (valid && rdy) begin
        got_data.push_back(data); got_tag.push_back(tag); got_last.push_back(last);
        if (last) pkt_done = 1;
      end
      stall = valid && !rdy; pd = data; pt = tag; pl = last;
      @(negedge clk);
    end
    snap = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; snap = 1'b1; snap2 = 1'b0; ready = 1'b1; pc = 32'h1234;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, busy, last, done, ovr, data, tag, cnt, rf_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v%b b%b l%b d%b o%b %h %0d %0d %0d exp all 0",
               valid, busy, last, done, ovr, data, tag, cnt, rf_addr);
    end
    checks++;
    if ({valid2, busy2, done2, cnt2} !== '0) begin
      errors++; $display("FAIL reset_lim got v%b b%b d%b c%0d exp 0", valid2, busy2, done2, cnt2);
    end
    snap = 1'b0; ready = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle got busy %b valid %b exp 0 0", busy, valid);
    end
  endtask

  task automatic test_single();
    pc = 32'h40;
    for (int i = 0; i < N; i++) regs[i] = 32'(3 * i);
    build_expected(pc);
    pulse_snap();
    checks++;
    if (valid !== 1'b1 || tag !== 6'd32) begin
      errors++; $display("FAIL single_first_beat got valid %b tag %0d exp 1 32", valid, tag);
    end
    collect(-1, 1'b0);
    checks++;
    if (!pkt_done || got_data.size() != exp_data.size()) begin
      errors++; $display("FAIL single_len got %0d exp %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_tag[i] !== exp_tag[i] || got_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL single_beat%0d got %h/%0d/%b exp %h/%0d/%b", i, got_data[i], got_tag[i],
                 got_last[i], exp_data[i], exp_tag[i], exp_last[i]);
      end
    end
    checks++;
    if (busy_cyc != 2 * N + 1) begin
      errors++; $display("FAIL single_busy_cycles got %0d exp %0d", busy_cyc, 2 * N + 1);
    end
    checks++;
    if (busy !== 1'b0 || cnt !== 8'd1 || ovr !== 1'b0) begin
      errors++; $display("FAIL single_after got busy %b cnt %0d ovr %b exp 0 1 0", busy, cnt, ovr);
    end
  endtask

  task automatic test_backpressure();
    pc = $urandom;
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    build_expected(pc);
    pulse_snap();
    collect(-1, 1'b1);
    checks++;
    if (!pkt_done || got_data.size() != exp_data.size()) begin
      errors++; $display("FAIL bp_len got %0d exp %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_tag[i] !== exp_tag[i] || got_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL bp_beat%0d got %h/%0d/%b exp %h/%0d/%b", i, got_data[i], got_tag[i],
                 got_last[i], exp_data[i], exp_tag[i], exp_last[i]);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++; $display("FAIL bp_stable got %0d unstable stalls exp 0", stall_viol);
    end
    checks++;
    if (cnt !== 8'd2) begin
      errors++; $display("FAIL bp_count got %0d exp 2", cnt);
    end
  endtask

  task automatic test_overrun();
    int extra_busy;
    pc = $urandom;
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    build_expected(pc);
    pulse_snap();
    collect(5, 1'b0);
    checks++;
    if (!pkt_done || got_data.size() != exp_data.size()) begin
      errors++; $display("FAIL ovr_len got %0d exp %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_tag[i] !== exp_tag[i]) begin
        errors++;
        $display("FAIL ovr_beat%0d got %h/%0d exp %h/%0d", i, got_data[i], got_tag[i],
                 exp_data[i], exp_tag[i]);
      end
    end
    extra_busy = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy || valid) extra_busy++;
      @(negedge clk);
    end
    checks++;
    if (extra_busy != 0) begin
      errors++; $display("FAIL ovr_second_packet got %0d busy cycles exp 0", extra_busy);
    end
    checks++;
    if (ovr !== 1'b1 || cnt !== 8'd3) begin
      errors++; $display("FAIL ovr_flag got ovr %b cnt %0d exp 1 3", ovr, cnt);
    end
  endtask

  task automatic test_limit();
    int lasts, hdrs;
    lasts = 0; hdrs = 0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk); snap2 = 1'b1;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk); snap2 = 1'b0;
        checks++;
        if (done2 !== (lasts >= 2)) begin
          errors++; $display("FAIL lim_done_timing got %b exp %b (pkt %0d)", done2, lasts >= 2, p);
        end
        if (valid2 && tag2 == 6'd32) hdrs++;
        if (valid2 && last2) lasts++;
      end
    end
    checks++;
    if (hdrs != 2 || lasts != 2) begin
      errors++; $display("FAIL lim_packets got %0d hdr %0d last exp 2 2", hdrs, lasts);
    end
    checks++;
    if (cnt2 !== 8'd2 || ovr2 !== 1'b0 || done2 !== 1'b1) begin
      errors++; $display("FAIL lim_final got cnt %0d ovr %b done %b exp 2 0 1", cnt2, ovr2, done2);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    pulse_snap();
    ready = 1'b1;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (valid && tag == 6'd10) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL arst_reach_tag10 got timeout exp tag 10 beat");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, busy, last, ovr, done, data, tag, cnt} !== '0) begin
      errors++;
      $display("FAIL arst_outputs got v%b b%b l%b o%b %h %0d %0d exp all 0",
               valid, busy, last, ovr, data, tag, cnt);
    end
    ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    pc = $urandom;
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    build_expected(pc);
    pulse_snap();
    collect(-1, 1'b1);
    checks++;
    if (!pkt_done || got_data.size() != exp_data.size()) begin
      errors++; $display("FAIL arst_len got %0d exp %0d", got_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_tag[i] !== exp_tag[i] || got_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL arst_beat%0d got %h/%0d/%b exp %h/%0d/%b", i, got_data[i], got_tag[i],
                 got_last[i], exp_data[i], exp_tag[i], exp_last[i]);
      end
    end
    checks++;
    if (cnt !== 8'd1 || ovr !== 1'b0) begin
      errors++; $display("FAIL arst_after got cnt %0d ovr %b exp 1 0", cnt, ovr);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_overrun();
    test_limit();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
